// File: rtl/wb_write_arbiter_if.sv
// rtl/wb_write_arbiter_if.sv - ALU/load result inputs and register-file write port bundle
// The arbiter connects through the slave modport; result producers and the register file use master.
interface wb_write_arbiter_if #(
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic          alu_valid;
  logic [4:0]    alu_rd;
  logic [31:0]   alu_wd;
  logic          alu_ready;
  logic          ld_valid;
  logic [4:0]    ld_rd;
  logic [31:0]   ld_wd;
  logic          ld_ready;
  logic          regwrite;
  logic [4:0]    rd;
  logic [31:0]   wd;
  logic [31:0]   pend;
  logic [CW-1:0] fifo_count;

  modport slave (
    input  alu_valid, alu_rd, alu_wd, ld_valid, ld_rd, ld_wd,
    output alu_ready, ld_ready, regwrite, rd, wd, pend, fifo_count
  );

  modport master (
    output alu_valid, alu_rd, alu_wd, ld_valid, ld_rd, ld_wd,
    input  alu_ready, ld_ready, regwrite, rd, wd, pend, fifo_count
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - merges ALU and queued load results onto one register-file write port
// ALU has priority; a starvation counter and WAW hold-off keep loads progressing and ordered.
module wb_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                clk,
  input  logic                rst,
  wb_write_arbiter_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [4:0]       mem_rd_q [DEPTH];
  logic [31:0]      mem_wd_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             regwrite_q, regwrite_d;
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      wd_q, wd_d;

  logic        empty, full, force_pop;
  logic        alu_ready, alu_win, pop, push;
  logic [31:0] pend_c;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign force_pop = (starve_q == SW'(STARVE_LIMIT));

  // x0 is never pushed, so bit 0 stays clear; masked anyway for safety.
  always_comb begin
    pend_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) pend_c[mem_rd_q[i]] = 1'b1;
    end
    pend_c[0] = 1'b0;
  end

  assign alu_ready = !force_pop && !((bus.alu_rd != 5'd0) && pend_c[bus.alu_rd]);
  assign alu_win   = bus.alu_valid && alu_ready && (bus.alu_rd != 5'd0);
  assign pop       = !alu_win && !empty;
  assign push      = bus.ld_valid && !full && (bus.ld_rd != 5'd0);

  always_comb begin
    regwrite_d = 1'b0;
    rd_d       = rd_q;
    wd_d       = wd_q;
    head_d     = head_q;
    tail_d     = tail_q;
    vld_d      = vld_q;
    count_d    = count_q;
    starve_d   = '0;

    if (alu_win) begin
      regwrite_d = 1'b1;
      rd_d       = bus.alu_rd;
      wd_d       = bus.alu_wd;
      if (!empty) starve_d = starve_q + SW'(1);
    end else if (pop) begin
      regwrite_d    = 1'b1;
      rd_d          = mem_rd_q[head_q];
      wd_d          = mem_wd_q[head_q];
      head_d        = head_q + PW'(1);
      vld_d[head_q] = 1'b0;
    end

    // Tail slot differs from head whenever a pop and push coincide (FIFO non-empty, not full).
    if (push) begin
      tail_d        = tail_q + PW'(1);
      vld_d[tail_q] = 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wd_q       <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      vld_q      <= '0;
      count_q    <= '0;
      starve_q   <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      wd_q       <= wd_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      vld_q      <= vld_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      if (push) begin
        mem_rd_q[tail_q] <= bus.ld_rd;
        mem_wd_q[tail_q] <= bus.ld_wd;
      end
    end
  end

  assign bus.alu_ready  = alu_ready;
  assign bus.ld_ready   = !full;
  assign bus.regwrite   = regwrite_q;
  assign bus.rd         = rd_q;
  assign bus.wd         = wd_q;
  assign bus.pend       = pend_c;
  assign bus.fifo_count = count_q;
endmodule
